aes_encrypt128_iter: RTL and testbench
======================================

# aes_encrypt128_iter

Iterative AES-128 encryption core, the forward-direction counterpart of the 128-bit decryption path. It accepts a cipher key and plaintext blocks over valid/ready handshakes and produces one ciphertext block per 11 clock cycles. Key expansion runs on the fly beside the round datapath, so only the cipher key is stored and no key-schedule buffer is needed. It sits beside the decryptor so the same key and block formats serve both directions.

## Interface
Parameters:
- NR, 10, number of rounds; fixed for AES-128, not a configuration point.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low: asserted when 0.
- kt  in  128  cipher key, [0:127]; byte 0 = bits 0:7 = FIPS-197 key byte 0.
- kt_vld  in  1  key valid.
- kt_rdy  out  1  core ready to accept a new key.
- pt  in  128  plaintext, [0:127], FIPS-197 byte order (byte n = state row n%4, column n/4).
- pt_vld  in  1  plaintext valid.
- pt_rdy  out  1  core ready to accept plaintext.
- ct  out  128  ciphertext, same byte order.
- ct_vld  out  1  one-cycle pulse when ct is updated.

## Operation
- Registers:
  - key_r: 128 bits, the stored cipher key.
  - key_ok: a key has been loaded.
  - busy.
  - rnd: 4 bits, 1..10.
  - st_r: 128-bit state.
  - rk_r: 128-bit current round key.
  - ct_r: 128-bit ciphertext.
  - ct_vld_r.
- Handshakes:
  - kt_rdy = ~busy.
  - pt_rdy = key_ok & ~busy & ~kt_vld. A key offered in the same cycle wins, and the block waits.
  - A transfer occurs on an edge where vld & rdy are both 1.
- Key accept: key_r ← kt, key_ok ← 1. Does not disturb ct/ct_vld.
- States:
  - NOKEY (key_ok=0): goes to IDLE on key accept.
  - IDLE: goes to RUN on block accept.
  - RUN: returns to IDLE after round 10. A key offered during RUN is held off (kt_rdy=0).
- Block accept (IDLE): st_r ← pt ^ key_r, rk_r ← key_r, rnd ← 1, busy ← 1.
- Each RUN edge:
  - rk_next = KeyStep(rk_r, Rcon[rnd]), where KeyStep is the FIPS-197 word recurrence using RotWord, SubWord and Rcon.
  - st_r ← AddRoundKey(MixColumns(ShiftRows(SubBytes(st_r))), rk_next).
  - MixColumns is skipped when rnd==10.
  - rk_r ← rk_next, rnd ← rnd+1.
- Round 10 edge: ct_r ← the round result (not st_r), ct_vld_r ← 1, busy ← 0.
- ct_vld is 1 for exactly one cycle per block. ct holds its value until the next completion.
- Rcon = 01,02,04,08,10,20,40,80,1B,36 for rnd 1..10.
- All GF(2^8) arithmetic uses polynomial x^8+x^4+x^3+x+1. xtime(b) = (b<<1) ^ (b[7] ? 1B : 00), with the bit-0 = LSB convention inside each byte.
- Reset (any time, including mid-RUN):
  - kt_rdy=1, pt_rdy=0, ct=0, ct_vld=0.
  - key_ok=0, busy=0, rnd=0.
  - Any in-flight block is discarded, and a key must be reloaded before the next block is accepted.

## Timing
- Latency: block accepted on edge E0 → ct/ct_vld valid in the cycle after edge E10, i.e. 10 edges after acceptance.
- Throughput: pt_rdy returns high in the ct_vld cycle, so back-to-back blocks are accepted on E0, E11, E22, … (11-cycle period).
- The new key is usable from the cycle after its accept edge. Key then block takes 2 edges minimum.
- ct_vld does not wait for a downstream ready; there is no backpressure on the output.
- The critical path is one round plus one key step in parallel, with no multi-cycle paths.

## Structure
- Package aes_enc_pkg holds:
  - the Rcon table as a function of rnd;
  - the NR constant;
  - a state_t typedef (logic [0:127]);
  - xtime and the MixColumns column function.
- Sub-module aes_enc_round is combinational: state_in, rkey_in, last → state_out. It instantiates 16 existing Sbox cells.
- The key step uses four further existing Sbox cells through SubWord/RotWord. It is inlined in the top module.
- The top module holds the FSM, the handshakes and all registers.

## Test plan
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a, with ct_vld pulsed exactly 10 edges after the pt accept edge.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32. Then hold pt_vld high with a second pt = 00..00: accepted exactly 11 cycles after the first, and ct updated again 10 edges later.
- Out of reset with pt_vld=1 and no key → pt_rdy stays 0, and no ct_vld for 50 cycles.
- kt_vld and pt_vld both high in IDLE → key accepted and pt_rdy=0 that cycle. The block is accepted next cycle and encrypted under the new key (C.1 values).
- New kt_vld during RUN → kt_rdy=0 until ct_vld. The current block completes with the old key (App. B result), and the next block uses the new key.
- rst pulled to 0 at round 5 → ct=0, ct_vld=0 and pt_rdy=0 immediately, with no ct_vld afterward. A key reload followed by the C.1 vector then passes.

Source files
------------

// File: rtl/aes_enc_pkg.sv
// aes_enc_pkg: shared constants, types and GF(2^8) helpers for the AES-128 encryptor
package aes_enc_pkg;
    localparam int NR = 10;
    typedef logic [0:127] state_t;
    typedef enum logic [1:0] {NOKEY, IDLE, RUN} fsm_t;
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        return (rnd == 4'd9) ? 8'h1b : (rnd == 4'd10) ? 8'h36 :
               (rnd inside {[4'd1:4'd8]}) ? 8'h01 << (rnd - 4'd1) : 8'h00;
    endfunction
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
    // Column bytes arrive row 0 first in the top byte
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction
endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: one combinational AES round; last skips MixColumns
module aes_enc_round
    import aes_enc_pkg::*;
(
    input  state_t state_in,
    input  state_t rkey_in,
    input  logic   last,
    output state_t state_out
);
    logic [7:0] sb [16];
    state_t sr, mc;
    // Byte g sits at row g%4, column g/4; row r rotates left by r columns
    for (genvar g = 0; g < 16; g++) begin : g_sb
        aes_sbox u_sbox (.a(state_in[8*g +: 8]), .s(sb[g]));
        assign sr[8*g +: 8] = sb[4*((g/4 + g%4) % 4) + g%4];
    end
    for (genvar c = 0; c < 4; c++) begin : g_mc
        assign mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
    end
    assign state_out = (last ? sr : mc) ^ rkey_in;
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: AES S-box cell, multiplicative inverse (a^254) followed by the affine map
module aes_sbox
    import aes_enc_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [7:0] inv, p;
    always_comb begin
        inv = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            inv = gmul(inv, p);
        end
    end
    assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
               {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_encrypt128_iter.sv
// aes_encrypt128_iter: iterative AES-128 encryptor, one round per cycle with on-the-fly key expansion
module aes_encrypt128_iter
    import aes_enc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] kt,
    input  logic         kt_vld,
    output logic         kt_rdy,
    input  logic [0:127] pt,
    input  logic         pt_vld,
    output logic         pt_rdy,
    output logic [0:127] ct,
    output logic         ct_vld
);
    fsm_t state, state_nxt;
    state_t key_r, st_r, rk_r, ct_r, rk_next, rnd_out;
    logic [3:0] rnd;
    logic ct_vld_r, key_ok, busy, last, kt_acc, pt_acc;
    logic [7:0] sw [4];
    logic [31:0] tmp, w0, w1, w2, w3;
    // SubWord(RotWord(w3)): bytes 13,14,15,12
    for (genvar g = 0; g < 4; g++) begin : g_sw
        aes_sbox u_sbox (.a(rk_r[8*(12 + (g+1) % 4) +: 8]), .s(sw[g]));
    end
    assign tmp = {sw[0] ^ rcon(rnd), sw[1], sw[2], sw[3]};
    assign w0 = rk_r[0 +: 32] ^ tmp;
    assign w1 = rk_r[32 +: 32] ^ w0;
    assign w2 = rk_r[64 +: 32] ^ w1;
    assign w3 = rk_r[96 +: 32] ^ w2;
    assign rk_next = {w0, w1, w2, w3};
    assign last = rnd == 4'(NR);
    aes_enc_round u_round (.state_in(st_r), .rkey_in(rk_next), .last(last), .state_out(rnd_out));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= NOKEY;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == NOKEY && kt_acc) ? IDLE :
                    (state == IDLE && pt_acc) ? RUN :
                    (state == RUN && last) ? IDLE : state;
    end
    always_comb begin
        key_ok = state != NOKEY;
        busy = state == RUN;
        kt_rdy = ~busy;
        pt_rdy = key_ok & ~busy & ~kt_vld;
        kt_acc = kt_vld & kt_rdy;
        pt_acc = pt_vld & pt_rdy;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_r <= '0;
            st_r <= '0;
            rk_r <= '0;
            ct_r <= '0;
            rnd <= '0;
            ct_vld_r <= 1'b0;
        end else begin
            ct_vld_r <= busy && last;
            if (kt_acc) key_r <= kt;
            if (pt_acc) begin
                st_r <= pt ^ key_r;
                rk_r <= key_r;
                rnd <= 4'd1;
            end else if (busy) begin
                st_r <= rnd_out;
                rk_r <= rk_next;
                rnd <= rnd + 4'd1;
            end
            if (busy && last) ct_r <= rnd_out;
        end
    end
    assign ct = ct_r;
    assign ct_vld = ct_vld_r;
endmodule

// File: tb/tb_aes_encrypt128_iter.sv
// tb_aes_encrypt128_iter: directed FIPS-197 vectors, handshake timing and reset behaviour
module tb_aes_encrypt128_iter;
    localparam logic [0:127] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    logic clk = 0, rst = 0, kt_vld = 0, pt_vld = 0, kt_rdy, pt_rdy, ct_vld;
    logic [0:127] kt = '0, pt = '0, ct;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    aes_encrypt128_iter dut (
        .clk(clk), .rst(rst), .kt(kt), .kt_vld(kt_vld), .kt_rdy(kt_rdy),
        .pt(pt), .pt_vld(pt_vld), .pt_rdy(pt_rdy), .ct(ct), .ct_vld(ct_vld)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic wait_ct(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ct_vld && n < 40);
    endtask
    initial begin
        int n;
        logic bad;
        step();
        step();
        pt = PB;
        pt_vld = 1;
        #1;
        chk("rst_kt_rdy", kt_rdy, 1);
        chk("rst_pt_rdy", pt_rdy, 0);
        chk("rst_ct", ct, 0);
        chk("rst_ct_vld", ct_vld, 0);
        rst = 1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            bad |= pt_rdy | ct_vld;
        end
        chk("nokey_no_accept", bad, 0);
        // Load App. B key, then back-to-back blocks
        pt_vld = 0;
        kt = KB;
        kt_vld = 1;
        #1;
        chk("nokey_kt_rdy", kt_rdy, 1);
        step();
        kt_vld = 0;
        #1;
        chk("key_usable", pt_rdy, 1);
        pt = PB;
        pt_vld = 1;
        step();
        pt = '0;
        chk("run_pt_rdy", pt_rdy, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (!pt_rdy && n < 40);
        chk("b2b_lat1", n, 10);
        chk("b2b_vld1", ct_vld, 1);
        chk("appB_ct", ct, CB);
        step();
        pt_vld = 0;
        chk("b2b_accept_11", pt_rdy, 0);
        chk("ct_vld_pulse", ct_vld, 0);
        chk("ct_hold", ct, CB);
        wait_ct(n);
        chk("b2b_lat2", n, 10);
        chk("b2b_ct2_changed", ct !== CB, 1);
        // Key and block offered together in IDLE
        kt = K1;
        kt_vld = 1;
        pt = P1;
        pt_vld = 1;
        #1;
        chk("both_pt_rdy", pt_rdy, 0);
        chk("both_kt_rdy", kt_rdy, 1);
        step();
        kt_vld = 0;
        #1;
        chk("both_pt_rdy_next", pt_rdy, 1);
        step();
        pt_vld = 0;
        wait_ct(n);
        chk("c1_lat", n, 10);
        chk("c1_ct", ct, C1);
        // New key offered during RUN
        kt = KB;
        kt_vld = 1;
        step();
        kt_vld = 0;
        pt = PB;
        pt_vld = 1;
        step();
        pt_vld = 0;
        kt = K1;
        kt_vld = 1;
        bad = 0;
        n = 0;
        do begin
            bad |= kt_rdy;
            step();
            n++;
        end while (!ct_vld && n < 40);
        chk("run_key_held_off", bad, 0);
        chk("run_key_lat", n, 10);
        chk("run_key_old_ct", ct, CB);
        chk("run_key_kt_rdy", kt_rdy, 1);
        step();
        kt_vld = 0;
        pt = P1;
        pt_vld = 1;
        #1;
        chk("run_key_pt_rdy", pt_rdy, 1);
        step();
        pt_vld = 0;
        wait_ct(n);
        chk("run_key_new_lat", n, 10);
        chk("run_key_new_ct", ct, C1);
        // Reset during round 5
        pt = P1;
        pt_vld = 1;
        step();
        pt_vld = 0;
        repeat (4) step();
        rst = 0;
        #1;
        chk("mid_rst_ct", ct, 0);
        chk("mid_rst_ct_vld", ct_vld, 0);
        chk("mid_rst_pt_rdy", pt_rdy, 0);
        chk("mid_rst_kt_rdy", kt_rdy, 1);
        step();
        rst = 1;
        pt_vld = 1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            bad |= ct_vld | pt_rdy;
        end
        chk("post_rst_quiet", bad, 0);
        pt_vld = 0;
        kt = K1;
        kt_vld = 1;
        step();
        kt_vld = 0;
        pt = P1;
        pt_vld = 1;
        step();
        pt_vld = 0;
        wait_ct(n);
        chk("reload_lat", n, 10);
        chk("reload_ct", ct, C1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
